// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the two-master memory port arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_arb_pkg;

    localparam int DEF_ADDR_W  = 16;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_TIMEOUT = 255;

    // One-hot encodings, same style as the cache controller FSMs.
    typedef enum logic [3:0] {
        ST_IDLE = 4'b0001,
        ST_BUSY = 4'b0010,
        ST_GAP  = 4'b0100,
        ST_HOLD = 4'b1000
    } arb_state_t;

    localparam logic OWNER_M0 = 1'b0;
    localparam logic OWNER_M1 = 1'b1;

    // Index of the current owner from the one-hot grant (M0 when none).
    function automatic logic owner_idx(input logic [1:0] g);
        return g[1] ? OWNER_M1 : OWNER_M0;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Cache-controller side of the memory port: request, line data, lock, completion.
// Latency: n/a (wires only).
// Backpressure: req is held by the master until rdy or err pulses.
import mem_arb_pkg::*;

interface mem_port_arbiter_if #(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) ();
    logic              req;
    logic              rw;
    logic              lock;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              rdy;
    logic              err;

    // Cache controller drives the request, sees completion.
    modport master (output req, rw, lock, addr, wdata, input rdata, rdy, err);
    // Arbiter sees the request, drives completion.
    modport slave  (input req, rw, lock, addr, wdata, output rdata, rdy, err);
endinterface

// File: rtl/mem_port_arbiter_rr_pick.sv
// Two-way round-robin pick: one-hot grant from the request pair and the rr pointer.
// Latency: combinational.
// Backpressure: none; requests that are not picked simply wait.
import mem_arb_pkg::*;

module mem_arb_rr_pick (
    input  logic [1:0] req,
    input  logic       rr,
    output logic [1:0] grant
);

    // Single requester always wins; a tie goes to the side rr points at.
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (rr == OWNER_M1) ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between two cache controllers: round-robin, optional lock, watchdog.
// Latency: mem_req rises one cycle after a request is seen; rdy/err are same-cycle with mem_rdy/expiry.
// Backpressure: losing requester holds req; the owner holds the port until rdy, err, or lock release.
import mem_arb_pkg::*;

module mem_port_arbiter #(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_port_arbiter_if.slave  m0,
    mem_port_arbiter_if.slave  m1,
    output logic               mem_req,
    output logic               mem_rw,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_wdata,
    input  logic [DATA_W-1:0]  mem_rdata,
    input  logic               mem_rdy,
    output logic [1:0]         gnt
);

    // A zero TIMEOUT disables the watchdog; keep the counter one bit wide then.
    localparam int              CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
    localparam logic             WDOG_EN  = (TIMEOUT > 0);

    arb_state_t       state;
    logic             rr;
    logic             lock_q;
    logic [CNT_W-1:0] cnt;

    logic [1:0] req_vec;
    logic [1:0] pick;
    logic       own;
    logic       own_req;
    logic       own_lock;
    logic       busy;
    logic       expire;

    assign req_vec  = {m1.req, m0.req};
    assign own      = owner_idx(gnt);
    assign own_req  = (own == OWNER_M1) ? m1.req  : m0.req;
    assign own_lock = (own == OWNER_M1) ? m1.lock : m0.lock;
    assign busy     = (state == ST_BUSY);
    // A completion in the expiry cycle takes priority over the abort.
    assign expire   = WDOG_EN && busy && !mem_rdy && (cnt == CNT_LAST);

    mem_arb_rr_pick u_pick (
        .req   (req_vec),
        .rr    (rr),
        .grant (pick)
    );

    // Memory only sees a request while a transaction is in flight, so GAP gives it an edge.
    assign mem_req = busy;

    // Route the owner's command to memory; drive zeros when nobody owns the port.
    always_comb begin
        mem_rw    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (gnt[0]) begin
            mem_rw    = m0.rw;
            mem_addr  = m0.addr;
            mem_wdata = m0.wdata;
        end else if (gnt[1]) begin
            mem_rw    = m1.rw;
            mem_addr  = m1.addr;
            mem_wdata = m1.wdata;
        end
    end

    assign m0.rdata = mem_rdata;
    assign m1.rdata = mem_rdata;
    assign m0.rdy   = busy & gnt[0] & mem_rdy;
    assign m1.rdy   = busy & gnt[1] & mem_rdy;
    assign m0.err   = expire & gnt[0];
    assign m1.err   = expire & gnt[1];

    // Grant/lock FSM with the watchdog counter; rr flips to the other side on every release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            gnt    <= 2'b00;
            rr     <= OWNER_M0;
            cnt    <= '0;
            lock_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|req_vec) begin
                        gnt   <= pick;
                        cnt   <= '0;
                        state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (cnt != '1) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                    if (mem_rdy) begin
                        lock_q <= own_lock;
                        state  <= ST_GAP;
                    end else if (expire) begin
                        lock_q <= 1'b0;
                        state  <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (lock_q) begin
                        state <= ST_HOLD;
                    end else begin
                        rr    <= ~own;
                        gnt   <= 2'b00;
                        state <= ST_IDLE;
                    end
                end
                ST_HOLD: begin
                    // A pending request wins over a lock drop in the same cycle.
                    if (own_req) begin
                        cnt   <= '0;
                        state <= ST_BUSY;
                    end else if (!own_lock) begin
                        lock_q <= 1'b0;
                        rr     <= ~own;
                        gnt    <= 2'b00;
                        state  <= ST_IDLE;
                    end
                end
                default: begin
                    gnt   <= 2'b00;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed, table-driven bench for mem_port_arbiter with a short watchdog (TIMEOUT=8).
// Latency: each table row is one clock; inputs change on negedge, outputs checked 1ns later.
// Backpressure: modelled by holding req in the rows until the expected rdy/err row.
import mem_arb_pkg::*;

module tb_mem_port_arbiter;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          mem_req;
    logic          mem_rw;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_rdy;
    logic [1:0]    gnt;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m0_if ();
    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m1_if ();

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .m0        (m0_if),
        .m1        (m1_if),
        .mem_req   (mem_req),
        .mem_rw    (mem_rw),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_rdy   (mem_rdy),
        .gnt       (gnt)
    );

    typedef struct packed {
        logic          req;
        logic          rw;
        logic          lock;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } cin_t;

    typedef struct {
        cin_t          c0;
        cin_t          c1;
        logic          rdy;
        logic [DW-1:0] rdata;
        logic [1:0]    e_gnt;
        logic          e_mreq;
        logic [1:0]    e_rdy;
        logic [1:0]    e_err;
    } vec_t;

    vec_t vt[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    function automatic cin_t ci(input logic req, input logic rw, input logic lock,
                                input logic [AW-1:0] a, input logic [DW-1:0] d);
        cin_t c;
        c.req = req; c.rw = rw; c.lock = lock; c.addr = a; c.wdata = d;
        return c;
    endfunction

    function automatic vec_t mk(input cin_t a, input cin_t b, input logic rdy,
                                input logic [DW-1:0] rd, input logic [1:0] g,
                                input logic mr, input logic [1:0] er, input logic [1:0] ee);
        vec_t v;
        v.c0 = a; v.c1 = b; v.rdy = rdy; v.rdata = rd;
        v.e_gnt = g; v.e_mreq = mr; v.e_rdy = er; v.e_err = ee;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input cin_t a, input cin_t b, input logic rdy, input logic [DW-1:0] rd);
        m0_if.req = a.req; m0_if.rw = a.rw; m0_if.lock = a.lock; m0_if.addr = a.addr; m0_if.wdata = a.wdata;
        m1_if.req = b.req; m1_if.rw = b.rw; m1_if.lock = b.lock; m1_if.addr = b.addr; m1_if.wdata = b.wdata;
        mem_rdy   = rdy;
        mem_rdata = rd;
    endtask

    // Expected memory command is the granted master's current inputs, zero when no grant.
    task automatic check_outs(input string tag, input cin_t a, input cin_t b, input logic [1:0] g,
                              input logic mr, input logic [1:0] er, input logic [1:0] ee,
                              input logic [DW-1:0] rd);
        logic          x_rw;
        logic [AW-1:0] x_addr;
        logic [DW-1:0] x_wd;
        x_rw = 1'b0; x_addr = '0; x_wd = '0;
        if (g == 2'b01) begin
            x_rw = a.rw; x_addr = a.addr; x_wd = a.wdata;
        end else if (g == 2'b10) begin
            x_rw = b.rw; x_addr = b.addr; x_wd = b.wdata;
        end
        chk({tag, " gnt"},       64'(gnt),       64'(g));
        chk({tag, " mem_req"},   64'(mem_req),   64'(mr));
        chk({tag, " mem_rw"},    64'(mem_rw),    64'(x_rw));
        chk({tag, " mem_addr"},  64'(mem_addr),  64'(x_addr));
        chk({tag, " mem_wdata"}, 64'(mem_wdata), 64'(x_wd));
        chk({tag, " rdy"},       64'({m1_if.rdy, m0_if.rdy}), 64'(er));
        chk({tag, " err"},       64'({m1_if.err, m0_if.err}), 64'(ee));
        if (er[0]) chk({tag, " m0_rdata"}, 64'(m0_if.rdata), 64'(rd));
        if (er[1]) chk({tag, " m1_rdata"}, 64'(m1_if.rdata), 64'(rd));
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < vt.size(); i++) begin
            @(negedge clk);
            drive(vt[i].c0, vt[i].c1, vt[i].rdy, vt[i].rdata);
            #1;
            check_outs($sformatf("%s[%0d]", tag, i), vt[i].c0, vt[i].c1, vt[i].e_gnt,
                       vt[i].e_mreq, vt[i].e_rdy, vt[i].e_err, vt[i].rdata);
        end
        vt.delete();
    endtask

    task automatic do_reset();
        cin_t z;
        z = ci(1'b0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        rst_n = 1'b0;
        drive(z, z, 1'b0, '0);
        #1;
        check_outs("reset", z, z, 2'b00, 1'b0, 2'b00, 2'b00, '0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        cin_t z, a, a_off, b, b1, b1_off;
        cin_t m0r, m0o, m1w, m1h, m1r, m1o, m0l, m0lo, m1r5, m1o5, m0r6, m0o6;

        z     = ci(1'b0, 1'b0, 1'b0, '0, '0);
        rst_n = 1'b0;
        drive(z, z, 1'b0, '0);

        // 1: single M0 read, memory answers on the 3rd cycle after mem_req; then rr=1 favours M1.
        do_reset();
        a      = ci(1'b1, 1'b0, 1'b0, 16'h1234, 32'h0);
        a_off  = ci(1'b0, 1'b0, 1'b0, 16'h1234, 32'h0);
        b1     = ci(1'b1, 1'b1, 1'b0, 16'h5678, 32'h0BAD_F00D);
        b1_off = ci(1'b0, 1'b1, 1'b0, 16'h5678, 32'h0BAD_F00D);
        vt.push_back(mk(a, z, 1'b0, '0, 2'b00, 1'b0, 2'b00, 2'b00));
        for (int i = 0; i < 3; i++)
            vt.push_back(mk(a, z, 1'b0, '0, 2'b01, 1'b1, 2'b00, 2'b00));
        vt.push_back(mk(a, z, 1'b1, 32'hDEAD_BEEF, 2'b01, 1'b1, 2'b01, 2'b00));
        vt.push_back(mk(a_off, z, 1'b0, '0, 2'b01, 1'b0, 2'b00, 2'b00));
        vt.push_back(mk(a_off, z, 1'b0, '0, 2'b00, 1'b0, 2'b00, 2'b00));
        vt.push_back(mk(a, b1, 1'b0, '0, 2'b00, 1'b0, 2'b00, 2'b00));
        vt.push_back(mk(a, b1, 1'b1, 32'h0, 2'b10, 1'b1, 2'b10, 2'b00));
        vt.push_back(mk(a_off, b1_off, 1'b0, '0, 2'b10, 1'b0, 2'b00, 2'b00));
        vt.push_back(mk(a_off, b1_off, 1'b0, '0, 2'b00, 1'b0, 2'b00, 2'b00));
        run_table("t1");

        // 2: both masters request continuously; M0,M1,M0,M1 with a GAP cycle (stray rdy ignored) then arbitration.
        do_reset();
        a = ci(1'b1, 1'b0, 1'b0, 16'h1000, 32'h1111_1111);
        b = ci(1'b1, 1'b0, 1'b0, 16'h2000, 32'h2222_2222);
        for (int t = 0; t < 4; t++) begin
            logic [1:0] g;
            g = (t % 2 == 1) ? 2'b10 : 2'b01;
            vt.push_back(mk(a, b, 1'b0, '0, 2'b00, 1'b0, 2'b00, 2'b00));
            vt.push_back(mk(a, b, 1'b0, '0, g, 1'b1, 2'b00, 2'b00));
            vt.push_back(mk(a, b, 1'b1, 32'hA000_0000 + 32'(t), g, 1'b1, g, 2'b00));
            vt.push_back(mk(a, b, 1'b1, '0, g, 1'b0, 2'b00, 2'b00));
        end
        vt.push_back(mk(z, z, 1'b0, '0, 2'b00, 1'b0, 2'b00, 2'b00));
        run_table("t2");

        // 3: M1 locked write-back + refill while M0 waits; HOLD idles while lock held without req.
        do_reset();
        m0r = ci(1'b1, 1'b0, 1'b0, 16'h3000, 32'h0);
        m0o = ci(1'b0, 1'b0, 1'b0, 16'h3000, 32'h0);
        m1w = ci(1'b1, 1'b1, 1'b1, 16'h0A04, 32'hCAFE_F00D);
        m1h = ci(1'b0, 1'b0, 1'b1, 16'h1204, 32'h0);
        m1r = ci(1'b1, 1'b0, 1'b0, 16'h1204, 32'h0);
        m1o = ci(1'b0, 1'b0, 1'b0, 16'h1204, 32'h0);
        vt.push_back(mk(z,   m1w, 1'b0, '0, 2'b00, 1'b0, 2'b00, 2'b00));
        vt.push_back(mk(m0r, m1w, 1'b0, '0, 2'b10, 1'b1, 2'b00, 2'b00));
        vt.push_back(mk(m0r, m1w, 1'b1, 32'h0, 2'b10, 1'b1, 2'b10, 2'b00));
        vt.push_back(mk(m0r, m1h, 1'b0, '0, 2'b10, 1'b0, 2'b00, 2'b00));
        vt.push_back(mk(m0r, m1h, 1'b1, '0, 2'b10, 1'b0, 2'b00, 2'b00));
        vt.push_back(mk(m0r, m1r, 1'b0, '0, 2'b10, 1'b0, 2'b00, 2'b00));
        vt.push_back(mk(m0r, m1r, 1'b1, 32'h55AA_55AA, 2'b10, 1'b1, 2'b10, 2'b00));
        vt.push_back(mk(m0r, m1o, 1'b0, '0, 2'b10, 1'b0, 2'b00, 2'b00));
        vt.push_back(mk(m0r, m1o, 1'b0, '0, 2'b00, 1'b0, 2'b00, 2'b00));
        vt.push_back(mk(m0r, m1o, 1'b1, 32'h0000_0077, 2'b01, 1'b1, 2'b01, 2'b00));
        vt.push_back(mk(m0o, m1o, 1'b0, '0, 2'b01, 1'b0, 2'b00, 2'b00));
        vt.push_back(mk(m0o, m1o, 1'b0, '0, 2'b00, 1'b0, 2'b00, 2'b00));
        run_table("t3");

        // 4: memory never answers; err on the 8th BUSY cycle, lock ignored after abort, then M1 served.
        do_reset();
        m0l  = ci(1'b1, 1'b0, 1'b1, 16'h4000, 32'h0);
        m0lo = ci(1'b0, 1'b0, 1'b1, 16'h4000, 32'h0);
        m1r5 = ci(1'b1, 1'b0, 1'b0, 16'h5000, 32'h0);
        m1o5 = ci(1'b0, 1'b0, 1'b0, 16'h5000, 32'h0);
        vt.push_back(mk(m0l, m1r5, 1'b0, '0, 2'b00, 1'b0, 2'b00, 2'b00));
        for (int i = 0; i < TO - 1; i++)
            vt.push_back(mk(m0l, m1r5, 1'b0, '0, 2'b01, 1'b1, 2'b00, 2'b00));
        vt.push_back(mk(m0l,  m1r5, 1'b0, '0, 2'b01, 1'b1, 2'b00, 2'b01));
        vt.push_back(mk(m0lo, m1r5, 1'b0, '0, 2'b01, 1'b0, 2'b00, 2'b00));
        vt.push_back(mk(m0lo, m1r5, 1'b0, '0, 2'b00, 1'b0, 2'b00, 2'b00));
        vt.push_back(mk(m0o,  m1r5, 1'b1, 32'h0000_0099, 2'b10, 1'b1, 2'b10, 2'b00));
        vt.push_back(mk(m0o,  m1o5, 1'b0, '0, 2'b10, 1'b0, 2'b00, 2'b00));
        vt.push_back(mk(m0o,  m1o5, 1'b0, '0, 2'b00, 1'b0, 2'b00, 2'b00));
        run_table("t4");

        // 5: async reset in the middle of BUSY, then a stray mem_rdy after release.
        do_reset();
        m0r6 = ci(1'b1, 1'b0, 1'b0, 16'h4444, 32'h0);
        @(negedge clk);
        drive(m0r6, z, 1'b0, '0);
        @(posedge clk);
        #2;
        chk("t5 busy mem_req", 64'(mem_req), 64'(1'b1));
        chk("t5 busy gnt",     64'(gnt),     64'(2'b01));
        rst_n = 1'b0;
        #1;
        chk("t5 async mem_req", 64'(mem_req), 64'(1'b0));
        chk("t5 async gnt",     64'(gnt),     64'(2'b00));
        @(negedge clk);
        drive(z, z, 1'b1, 32'h1234_5678);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_outs("t5 stray0", z, z, 2'b00, 1'b0, 2'b00, 2'b00, '0);
        @(posedge clk);
        #1;
        check_outs("t5 stray1", z, z, 2'b00, 1'b0, 2'b00, 2'b00, '0);
        @(negedge clk);
        drive(z, z, 1'b0, '0);

        // 6: mem_rdy lands exactly in the watchdog expiry cycle; completion wins.
        do_reset();
        m0r6 = ci(1'b1, 1'b0, 1'b0, 16'h6000, 32'h0);
        m0o6 = ci(1'b0, 1'b0, 1'b0, 16'h6000, 32'h0);
        vt.push_back(mk(m0r6, z, 1'b0, '0, 2'b00, 1'b0, 2'b00, 2'b00));
        for (int i = 0; i < TO - 1; i++)
            vt.push_back(mk(m0r6, z, 1'b0, '0, 2'b01, 1'b1, 2'b00, 2'b00));
        vt.push_back(mk(m0r6, z, 1'b1, 32'hFEED_FACE, 2'b01, 1'b1, 2'b01, 2'b00));
        vt.push_back(mk(m0o6, z, 1'b0, '0, 2'b01, 1'b0, 2'b00, 2'b00));
        vt.push_back(mk(m0o6, z, 1'b0, '0, 2'b00, 1'b0, 2'b00, 2'b00));
        run_table("t6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
